// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Definitions shared by the UART byte path (uart_tx, uart_rx,
//                uart_tx_arbiter): the byte width and the arbiter's
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Arbiter state encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority encoder. Scans the request
//                vector starting one position above i_last and wraps, so
//                the previous winner has the lowest priority.
//  Ports       : i_req    - request vector, one bit per requester
//                i_last   - index of the previous winner
//                o_winner - index of the selected requester (i_last if none)
//                o_any    - high when any request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_last,
    output logic [IDW-1:0] o_winner,
    output logic           o_any
);

    always_comb begin
        logic w_found;
        w_found  = 1'b0;
        o_any    = |i_req;
        o_winner = i_last;
        // Offset k=1 is the highest priority; k=N revisits i_last itself,
        // so a lone requester always wins again.
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && (j == ((int'(i_last) + k) % N)) && i_req[j]) begin
                    o_winner = IDW'(j);
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one uart_tx byte transmitter
//                between NUM_REQ message sources. A grant is held for a
//                whole message, up to MAX_BURST bytes, and is revoked if the
//                grantee stalls for GAP_TIMEOUT clocks mid-message. Each byte
//                is launched with a one-cycle tx_start and paced on tx_done.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                req_valid/req_data/req_last/req_ready - per-requester byte
//                                stream (ready is combinational)
//                tx_start/tx_data - registered launch pulse and byte
//                tx_busy/tx_done  - transmitter status
//                grant_id/grant_active - current (or last) grantee
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int MAX_BURST   = 8,
    parameter  int GAP_TIMEOUT = 16,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [IDW-1:0]                 grant_id,
    output logic                           grant_active
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    localparam logic [BW-1:0]  c_BURST_MAX = BW'(MAX_BURST);
    localparam logic [GW-1:0]  c_GAP_LAST  = GW'(GAP_TIMEOUT - 1);
    localparam logic [IDW-1:0] c_LAST_ID   = IDW'(NUM_REQ - 1);

    logic [1:0]             r_state;
    logic [IDW-1:0]         r_grant_id;
    logic                   r_grant_active;
    logic [IDW-1:0]         r_last_grant;
    logic [BW-1:0]          r_burst_cnt;
    logic [GW-1:0]          r_gap_cnt;
    logic                   r_last_flag;
    logic                   r_tx_start;
    logic [UART_DATA_W-1:0] r_tx_data;

    logic [IDW-1:0]         w_winner;
    logic                   w_any;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [UART_DATA_W-1:0] w_sel_data;
    logic                   w_ready_en;
    logic                   w_xfer;

    rr_pick #(
        .N        (NUM_REQ)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_last   (r_last_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Route the grantee's byte stream onto a single set of wires.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == IDW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[UART_DATA_W*i +: UART_DATA_W];
            end
        end
    end

    assign w_ready_en = (r_state == ST_ISSUE) && !tx_busy;
    assign w_xfer     = w_ready_en && w_sel_valid;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_ready_en && (r_grant_id == IDW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_grant_id     <= '0;
            r_grant_active <= 1'b0;
            r_last_grant   <= c_LAST_ID;
            r_burst_cnt    <= '0;
            r_gap_cnt      <= '0;
            r_last_flag    <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id     <= w_winner;
                        r_grant_active <= 1'b1;
                        r_burst_cnt    <= '0;
                        r_gap_cnt      <= '0;
                        r_state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_xfer) begin
                        r_tx_start  <= 1'b1;
                        r_tx_data   <= w_sel_data;
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        r_last_flag <= w_sel_last;
                        r_gap_cnt   <= '0;
                        r_state     <= ST_WAIT_DONE;
                    end else if (!tx_busy && !w_sel_valid) begin
                        // Stall timer only runs while the transmitter could
                        // have taken a byte; busy time is not the source's fault.
                        if (r_gap_cnt == c_GAP_LAST) begin
                            r_last_grant   <= r_grant_id;
                            r_grant_active <= 1'b0;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        // End of message and burst limit collapse into one
                        // release; the counter never passes MAX_BURST.
                        if (r_last_flag || (r_burst_cnt == c_BURST_MAX)) begin
                            r_last_grant   <= r_grant_id;
                            r_grant_active <= 1'b0;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    r_grant_active <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start     = r_tx_start;
    assign tx_data      = r_tx_data;
    assign grant_id     = r_grant_id;
    assign grant_active = r_grant_active;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter (4 requesters,
//                burst 8, gap timeout 16) with a transmitter model that
//                pulses tx_done ten clocks after each tx_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int MB   = 8;
    localparam int GT   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]  req_last;
    logic [NREQ-1:0]  req_ready;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic             tx_done;
    logic [1:0]       grant_id;
    logic             grant_active;

    logic             m_busy;
    logic             force_busy;
    int               m_cnt;

    // Per-requester byte queues: {last, data}
    logic [8:0]       mem [NREQ][16];
    int               len [NREQ];
    int               ptr [NREQ];

    // Observation logs
    logic [1:0]       cap_gid [64];
    logic [7:0]       cap_dat [64];
    int               ncap;
    logic [1:0]       glog [32];
    int               nglog;
    int               rdy_cnt [NREQ];
    logic             ga_prev;

    int               errs   = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    assign tx_busy = m_busy | force_busy;

    uart_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .MAX_BURST   (MB),
        .GAP_TIMEOUT (GT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = (ptr[i] < len[i]);
            req_last[i]        = mem[i][ptr[i][3:0]][8];
            req_data[8*i +: 8] = mem[i][ptr[i][3:0]][7:0];
        end
    end

    // Transmitter model, source pop on handshake, and logging.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            tx_done <= 1'b0;
            ncap    <= 0;
            nglog   <= 0;
            ga_prev <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                ptr[i]     <= 0;
                rdy_cnt[i] <= 0;
            end
        end else begin
            tx_done <= 1'b0;
            if (tx_start) begin
                m_busy            <= 1'b1;
                m_cnt             <= 9;
                cap_gid[ncap[5:0]] <= grant_id;
                cap_dat[ncap[5:0]] <= tx_data;
                ncap              <= ncap + 1;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    tx_done <= 1'b1;
                    m_busy  <= 1'b0;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
                if (req_valid[i] && req_ready[i]) ptr[i] <= ptr[i] + 1;
            end
            ga_prev <= grant_active;
            if (grant_active && !ga_prev) begin
                glog[nglog[4:0]] <= grant_id;
                nglog            <= nglog + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic begin_reset();
        rst        = 1'b1;
        force_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) len[i] = 0;
        #1;
    endtask

    task automatic end_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_msg(input int r, input logic [7:0] b, input logic last);
        mem[r][len[r]] = {last, b};
        len[r]         = len[r] + 1;
    endtask

    function automatic logic drained();
        for (int i = 0; i < NREQ; i++) if (ptr[i] != len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string nm);
        int c;
        c = 0;
        @(negedge clk);
        while (!(drained() && !grant_active && !tx_busy) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 3000) timeout_fail(nm);
    endtask

    typedef struct {
        logic [3:0]      mask;
        int              msgs;
        int              n;
        logic [7:0][1:0] exp;  // exp[0] is the first expected grant
    } rr_vec_t;

    rr_vec_t tv [5];

    initial begin
        int c;
        int nd;
        begin_reset();
        end_reset();

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("reset tx_start",     32'(tx_start),     0);
        chk("reset tx_data",      32'(tx_data),      0);
        chk("reset grant_id",     32'(grant_id),     0);
        chk("reset grant_active", 32'(grant_active), 0);
        chk("reset req_ready",    32'(req_ready),    0);

        // ---------------- round-robin table ----------------
        tv[0] = '{4'b1111, 2, 8, {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        tv[1] = '{4'b0110, 1, 2, {12'd0, 2'd2, 2'd1}};
        tv[2] = '{4'b1001, 1, 2, {12'd0, 2'd3, 2'd0}};
        tv[3] = '{4'b1000, 2, 2, {12'd0, 2'd3, 2'd3}};
        tv[4] = '{4'b0101, 2, 4, {8'd0, 2'd2, 2'd0, 2'd2, 2'd0}};

        for (int t = 0; t < 5; t++) begin
            begin_reset();
            for (int m = 0; m < tv[t].msgs; m++)
                for (int i = 0; i < NREQ; i++)
                    if (tv[t].mask[i]) load_msg(i, 8'(8'hA0 + i), 1'b1);
            end_reset();
            wait_idle($sformatf("rr%0d idle", t));
            chk($sformatf("rr%0d grant count", t), nglog, tv[t].n);
            chk($sformatf("rr%0d byte count", t),  ncap,  tv[t].n);
            for (int k = 0; k < tv[t].n; k++) begin
                chk($sformatf("rr%0d grant[%0d]", t, k), 32'(glog[k]), 32'(tv[t].exp[k]));
                chk($sformatf("rr%0d byte[%0d]", t, k),  32'(cap_dat[k]), 32'(8'hA0) + 32'(tv[t].exp[k]));
            end
            for (int i = 0; i < NREQ; i++)
                chk($sformatf("rr%0d ready cycles req%0d", t, i), rdy_cnt[i],
                    tv[t].mask[i] ? tv[t].msgs : 0);
        end

        // ---------------- single requester, 3-byte message ----------------
        begin_reset();
        load_msg(1, 8'h41, 1'b0);
        load_msg(1, 8'h42, 1'b0);
        load_msg(1, 8'h43, 1'b1);
        end_reset();
        nd = 0;
        c  = 0;
        while (nd < 3 && c < 300) begin
            @(negedge clk);
            c++;
            if (tx_done) nd++;
            if (grant_active) chk("msg3 grant_id during", 32'(grant_id), 1);
        end
        if (nd < 3) timeout_fail("msg3 tx_done");
        chk("msg3 active at 3rd done", 32'(grant_active), 1);
        @(negedge clk);
        chk("msg3 active after 3rd done", 32'(grant_active), 0);
        chk("msg3 grant_id held", 32'(grant_id), 1);
        chk("msg3 byte count", ncap, 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("msg3 byte[%0d]", k), 32'(cap_dat[k]), 32'h41 + 32'(k));
            chk($sformatf("msg3 gid[%0d]", k),  32'(cap_gid[k]), 1);
        end

        // ---------------- burst limit with a waiting requester ----------------
        begin_reset();
        for (int k = 0; k < 12; k++) load_msg(2, 8'(8'h20 + k), (k == 11));
        load_msg(3, 8'h30, 1'b1);
        end_reset();
        wait_idle("burst idle");
        chk("burst byte count", ncap, 13);
        chk("burst grant count", nglog, 3);
        chk("burst grant[0]", 32'(glog[0]), 2);
        chk("burst grant[1]", 32'(glog[1]), 3);
        chk("burst grant[2]", 32'(glog[2]), 2);
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("burst gid[%0d]", k), 32'(cap_gid[k]),
                (k == 8) ? 32'd3 : 32'd2);
            chk($sformatf("burst byte[%0d]", k), 32'(cap_dat[k]),
                (k < 8) ? 32'h20 + 32'(k) : (k == 8) ? 32'h30 : 32'h20 + 32'(k - 1));
        end

        // ---------------- gap timeout ----------------
        begin_reset();
        load_msg(0, 8'h10, 1'b0);
        load_msg(2, 8'h50, 1'b1);
        end_reset();
        c = 0;
        @(negedge clk);
        while (!tx_done && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) timeout_fail("gap first done");
        c = 0;
        @(negedge clk);
        while (grant_active && c < 100) begin
            c++;
            @(negedge clk);
        end
        chk("gap ISSUE clocks before release", c, GT);
        chk("gap grant_active released", 32'(grant_active), 0);
        chk("gap grant_id held", 32'(grant_id), 0);
        wait_idle("gap idle");
        chk("gap grant count", nglog, 2);
        chk("gap next grantee", 32'(glog[1]), 2);
        chk("gap next byte", 32'(cap_dat[1]), 32'h50);

        // ---------------- tx_busy on entry to ISSUE ----------------
        begin_reset();
        force_busy = 1'b1;
        load_msg(1, 8'h61, 1'b1);
        end_reset();
        c = 0;
        @(negedge clk);
        while (!grant_active && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (c >= 50) timeout_fail("busy grant");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("busy req_ready[%0d]", k), 32'(req_ready), 0);
            chk($sformatf("busy tx_start[%0d]", k),  32'(tx_start), 0);
            chk($sformatf("busy gap_cnt[%0d]", k),   32'(dut.r_gap_cnt), 0);
        end
        force_busy = 1'b0;
        #1;
        chk("busy ready on release", 32'(req_ready), 32'b0010);
        @(negedge clk);
        chk("busy tx_start after release", 32'(tx_start), 1);
        chk("busy tx_data after release", 32'(tx_data), 32'h61);
        wait_idle("busy idle");

        // ---------------- asynchronous reset mid-transfer ----------------
        begin_reset();
        load_msg(1, 8'h71, 1'b0);
        load_msg(1, 8'h72, 1'b1);
        end_reset();
        c = 0;
        @(negedge clk);
        while (!tx_start && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (c >= 50) timeout_fail("rst tx_start");
        rst = 1'b1;
        #1;
        chk("async rst tx_start",     32'(tx_start),     0);
        chk("async rst tx_data",      32'(tx_data),      0);
        chk("async rst grant_id",     32'(grant_id),     0);
        chk("async rst grant_active", 32'(grant_active), 0);
        chk("async rst req_ready",    32'(req_ready),    0);
        for (int i = 0; i < NREQ; i++) len[i] = 0;
        load_msg(0, 8'h80, 1'b1);
        load_msg(1, 8'h81, 1'b1);
        end_reset();
        wait_idle("rst idle");
        chk("post-rst first grant",  32'(glog[0]), 0);
        chk("post-rst second grant", 32'(glog[1]), 1);
        chk("post-rst first byte",   32'(cap_dat[0]), 32'h80);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx byte transmitter between NUM_REQ message sources (e.g. loopback echo from uart_rx, status reporter, debug console). It grants one requester at a time for a whole message, bounded by a burst limit. It issues one-cycle tx_start pulses and paces each byte on the transmitter's tx_done.

Parameters:
- NUM_REQ, 4, number of requesters (1..8)
- MAX_BURST, 8, max bytes per grant before forced rotation (≥1)
- GAP_TIMEOUT, 16, clocks a granted requester may leave req_valid low mid-message before its grant is revoked (≥1)

Ports:
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]
- req_last  in  NUM_REQ  byte is last of message; qualified by req_valid
- req_ready  out  NUM_REQ  combinational; byte accepted when valid&ready
- tx_start  out  1  registered one-cycle pulse to transmitter
- tx_data  out  8  registered byte; stable from tx_start until next transfer
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle pulse when stop bit finishes
- grant_id  out  $clog2(NUM_REQ) (min 1)  current or last grantee
- grant_active  out  1  high while a grant is held

Behaviour:
- Reset (async, immediate): state=IDLE, tx_start=0, tx_data=0, grant_id=0, grant_active=0, last_grant=NUM_REQ-1 so requester 0 has first priority. Counters cleared. A reset mid-byte drops tx_start at once; no byte is replayed.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE: if any req_valid, winner = first set bit scanning (last_grant+1) mod NUM_REQ upward with wrap. Next edge: grant_id=winner, grant_active=1, burst_cnt=0, gap_cnt=0, go to ISSUE. Arbitration latency is 1 clk; req_ready is low in IDLE.
- ISSUE: req_ready[grant_id] = !tx_busy. All other ready bits are 0.
  - Transfer (valid&ready) → next edge: tx_start=1 for exactly one clk, tx_data=byte, burst_cnt+1, last_flag=req_last[grant_id], gap_cnt=0, go to WAIT_DONE.
  - If req_valid[grant_id] is low, gap_cnt counts up. When gap_cnt reaches GAP_TIMEOUT-1, release the grant (see Release).
  - While tx_busy is high, gap_cnt holds.
- WAIT_DONE: grant_active stays high. On tx_done:
  - if last_flag or burst_cnt==MAX_BURST → release.
  - else → ISSUE.
- Release: last_grant=grant_id, grant_active=0, state IDLE. grant_id holds its value.
  - The released requester is lowest priority in the next arbitration, so if others are pending, a mid-message requester is interrupted at the burst limit.
  - The earliest re-grant is 1 clk after release (through IDLE).
- tx_done outside WAIT_DONE is ignored. Changes on non-granted req_* lines have no effect.
- Simultaneous req_last on byte MAX_BURST releases once, with no double count.
- Widths: burst_cnt is $clog2(MAX_BURST+1) bits and saturates by construction. gap_cnt is $clog2(GAP_TIMEOUT+1) bits.
- NUM_REQ=1: the arbiter degenerates to the same requester always; timeouts and burst limits still apply.

Decomposition:
- Shared package uart_pkg: state encoding localparams (ST_IDLE, ST_ISSUE, ST_WAIT_DONE) and UART_DATA_W=8, shared with uart_tx/uart_rx.
- One sub-module, rr_pick: combinational rotating-priority encoder.
  - Inputs: req vector, last_grant.
  - Outputs: winner index, any_req.
  - Reusable by future arbiters.

Test Plan:
- Single requester 1 sends 3-byte message 0x41,0x42,0x43 (last on 0x43), transmitter model with tx_done 10 clks after tx_start → three tx_start pulses in order, grant_id=1 throughout, grant_active drops 1 clk after the 3rd tx_done.
- All four requesters continuously valid with 1-byte messages from reset → grant order 0,1,2,3,0; each requester's req_ready asserted exactly once per round.
- Requester 2 streams 12 bytes with MAX_BURST=8 while requester 3 waits → 8 bytes from 2, then grant to 3, then 2 resumes with bytes 9–12; byte order preserved.
- Granted requester drops req_valid after 1st non-last byte for 20 clks (GAP_TIMEOUT=16) → grant released after 16 ISSUE clks, grant_active=0, next pending requester granted.
- tx_busy held high on entry to ISSUE for 5 clks → req_ready low for those 5 clks, no tx_start, gap_cnt not advancing; transfer occurs on the first clk busy falls.
- Assert rst during WAIT_DONE with tx_start pending → all outputs at reset values same cycle; after release, requester 0 granted first.
